// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// No logic; pure declarations plus a small address-check helper.
// Not applicable: no flow control lives here.
package imem_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // A fetch address is illegal if it is not word aligned or runs past the last word.
  function automatic logic fetch_addr_bad(input logic [31:0] addr, input logic [31:0] last_addr);
    return (addr[1:0] != 2'b00) || (addr > last_addr);
  endfunction

endpackage

// File: rtl/imem_skid_buf.sv
// One-entry {instr, pc} holding register absorbing the memory read latency.
// Latency: a loaded entry is visible on dout the cycle after load.
// Backpressure: owner decides load/pop; flush wins over load, load wins over pop.
module imem_skid_buf
  import imem_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         pop,
  input  fetch_entry_t din,
  output logic         full,
  output fetch_entry_t dout
);

  // Occupancy and payload; a load while full simply replaces the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a sync-read instruction memory plus byte-wide boot-loader port.
// Latency: first instruction 2 cycles after start, then 1/cycle; redirect target valid next cycle.
// Backpressure: at most 2 outstanding (1 in flight + 1 skid); while stalled with both full the in-flight word is re-read.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt,
  input  logic               ld_valid,
  input  logic [31:0]        ld_addr,
  input  logic [BYTE_W-1:0]  ld_data,
  output logic               ld_ready,
  input  logic               ld_done,
  output logic [31:0]        mem_addr,
  output logic               mem_we,
  output logic [BYTE_W-1:0]  mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               fault
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_SIZE - PC_STEP);
  localparam logic [31:0] MAX_BYTE  = 32'(MEM_SIZE - 1);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic         infl, infl_nx;
  logic [31:0]  infl_pc;
  logic         skid_flush, skid_load, skid_pop, skid_full;
  fetch_entry_t skid_din, skid_dout, cand;
  logic         cand_vld, xfer, can_issue;

  // pc always points one word past the in-flight fetch, so its address is implied.
  assign infl_pc  = pc - 32'(PC_STEP);
  assign skid_din = {mem_rdata, infl_pc};
  assign fault    = (state == FAULT);

  imem_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (skid_flush),
    .load  (skid_load),
    .pop   (skid_pop),
    .din   (skid_din),
    .full  (skid_full),
    .dout  (skid_dout)
  );

  // Controller state, fetch pointer and in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      infl  <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      infl  <= infl_nx;
    end
  end

  // Next state, memory port, loader handshake and decode-side outputs.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    infl_nx     = infl;
    mem_addr    = pc;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    ld_ready    = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    skid_flush  = 1'b0;
    skid_load   = 1'b0;
    skid_pop    = 1'b0;
    cand_vld    = skid_full | infl;
    cand        = skid_full ? skid_dout : skid_din;
    xfer        = 1'b0;
    can_issue   = 1'b0;

    case (state)
      IDLE: begin
        if (ld_valid)   state_nx = LOAD;
        else if (start) state_nx = FETCH;
      end

      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
          mem_we    = (ld_addr <= MAX_BYTE);
        end
        if (ld_done) state_nx = IDLE;
      end

      FETCH: begin
        if (redirect_valid) begin
          // Whole stream is stale: drop everything and fetch the target right away.
          skid_flush = 1'b1;
          if (fetch_addr_bad(redirect_pc, LAST_ADDR)) begin
            state_nx = FAULT;
            infl_nx  = 1'b0;
          end else begin
            mem_addr = redirect_pc;
            infl_nx  = 1'b1;
            pc_nx    = redirect_pc + 32'(PC_STEP);
          end
        end else begin
          instr_valid = cand_vld;
          if (cand_vld) begin
            instr    = cand.instr;
            instr_pc = cand.pc;
          end
          xfer = cand_vld & instr_ready;

          if (halt) begin
            // Rewind to the oldest word decode has not taken yet.
            state_nx   = IDLE;
            infl_nx    = 1'b0;
            skid_flush = 1'b1;
            if (skid_full && !xfer)            pc_nx = skid_dout.pc;
            else if (infl && (skid_full || !xfer)) pc_nx = infl_pc;
            else                                pc_nx = pc;
          end else begin
            can_issue = !skid_full || xfer;
            if (skid_full) begin
              if (xfer) begin
                if (infl) skid_load = 1'b1;
                else      skid_pop  = 1'b1;
              end else if (infl) begin
                // Nowhere to park the arriving word: read the same address again.
                mem_addr = infl_pc;
              end
            end else if (infl && !xfer) begin
              skid_load = 1'b1;
            end

            if (can_issue) begin
              if (fetch_addr_bad(pc, LAST_ADDR)) begin
                state_nx   = FAULT;
                infl_nx    = 1'b0;
                skid_flush = 1'b1;
              end else begin
                mem_addr = pc;
                infl_nx  = 1'b1;
                pc_nx    = pc + 32'(PC_STEP);
              end
            end
          end
        end
      end

      FAULT: begin
        state_nx = FAULT;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
